// File: rtl/cronometro_pkg.sv
// Shared types and constants for the stopwatch/countdown core.
package cronometro_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [3:0] DEC_MAX = 4'd9;

endpackage

// File: rtl/cronometro_ctrl_if.sv
// Control pulses from the button front end and count/status values to the display driver.
interface cronometro_ctrl_if #(
    parameter int SEC_W = 10
);
    logic             start_stop;
    logic             clear;
    logic             lap;
    logic             mode_down;
    logic [SEC_W-1:0] load_seg;
    logic [3:0]       cont_dec;
    logic [SEC_W-1:0] cont_seg;
    logic [3:0]       lap_dec;
    logic [SEC_W-1:0] lap_seg;
    logic             lap_valid;
    logic             running;
    logic             expired;
    logic             tick;

    modport master (
        output start_stop, clear, lap, mode_down, load_seg,
        input  cont_dec, cont_seg, lap_dec, lap_seg, lap_valid, running, expired, tick
    );

    modport slave (
        input  start_stop, clear, lap, mode_down, load_seg,
        output cont_dec, cont_seg, lap_dec, lap_seg, lap_valid, running, expired, tick
    );

endinterface

// File: rtl/cronometro_ctrl_tick_gen.sv
// Prescaler: divides clk down to one step strobe every CLK_PER_TENTH enabled cycles.
module tick_gen #(
    parameter int CLK_PER_TENTH = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic clr,
    output logic tick
);

    localparam int            CW   = $clog2(CLK_PER_TENTH + 1);
    localparam logic [CW-1:0] LAST = CW'(CLK_PER_TENTH - 1);

    logic [CW-1:0] cnt;

    // Strobe is combinational so the counters step on the same edge the phase wraps.
    assign tick = enable && (cnt == LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/cronometro_ctrl.sv
// Stopwatch/countdown controller: run/pause FSM, tenths/seconds stepping, lap capture, expiry.
module cronometro_ctrl
    import cronometro_pkg::*;
#(
    parameter int CLK_PER_TENTH = 10,
    parameter int SEC_W         = 10,
    parameter int SEC_MAX       = 999
) (
    input logic              clk,
    input logic              reset,
    cronometro_ctrl_if.slave bus
);

    localparam logic [SEC_W-1:0] SEC_LAST = SEC_W'(SEC_MAX);

    state_t           state;
    logic             mode_q;
    logic [3:0]       dec_q;
    logic [SEC_W-1:0] seg_q;
    logic [3:0]       lap_dec_q;
    logic [SEC_W-1:0] lap_seg_q;
    logic             lap_valid_q;
    logic             running_q;
    logic             expired_q;
    logic             tick_q;

    logic             step;
    logic [3:0]       dec_nxt;
    logic [SEC_W-1:0] seg_nxt;
    logic             hit_zero;

    tick_gen #(
        .CLK_PER_TENTH(CLK_PER_TENTH)
    ) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .enable(state == RUN),
        .clr   (bus.clear),
        .tick  (step)
    );

    always_comb begin
        dec_nxt = dec_q;
        seg_nxt = seg_q;
        if (!mode_q) begin
            if (dec_q == DEC_MAX) begin
                dec_nxt = '0;
                seg_nxt = (seg_q == SEC_LAST) ? '0 : seg_q + 1'b1;
            end else begin
                dec_nxt = dec_q + 4'd1;
            end
        end else begin
            // A running countdown never sits at 0.0, so the borrow cannot underflow.
            if (dec_q == 4'd0) begin
                dec_nxt = DEC_MAX;
                seg_nxt = seg_q - 1'b1;
            end else begin
                dec_nxt = dec_q - 4'd1;
            end
        end
        hit_zero = mode_q && (dec_nxt == 4'd0) && (seg_nxt == '0);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            mode_q      <= 1'b0;
            dec_q       <= '0;
            seg_q       <= '0;
            lap_dec_q   <= '0;
            lap_seg_q   <= '0;
            lap_valid_q <= 1'b0;
            running_q   <= 1'b0;
            expired_q   <= 1'b0;
            tick_q      <= 1'b0;
        end else if (bus.clear) begin
            state       <= IDLE;
            dec_q       <= '0;
            seg_q       <= '0;
            lap_dec_q   <= '0;
            lap_seg_q   <= '0;
            lap_valid_q <= 1'b0;
            running_q   <= 1'b0;
            expired_q   <= 1'b0;
            tick_q      <= 1'b0;
        end else begin
            tick_q <= 1'b0;
            if (bus.lap && (state == RUN || state == PAUSE)) begin
                lap_dec_q   <= dec_q;
                lap_seg_q   <= seg_q;
                lap_valid_q <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (bus.start_stop) begin
                        mode_q <= bus.mode_down;
                        if (bus.mode_down && bus.load_seg == '0) begin
                            state     <= DONE;
                            expired_q <= 1'b1;
                        end else begin
                            state     <= RUN;
                            running_q <= 1'b1;
                            dec_q     <= '0;
                            if (bus.mode_down) begin
                                seg_q <= (bus.load_seg > SEC_LAST) ? SEC_LAST : bus.load_seg;
                            end
                        end
                    end
                end
                RUN: begin
                    if (step) begin
                        dec_q  <= dec_nxt;
                        seg_q  <= seg_nxt;
                        tick_q <= 1'b1;
                    end
                    // Reaching 0.0 outranks a simultaneous pause request.
                    if (step && hit_zero) begin
                        state     <= DONE;
                        running_q <= 1'b0;
                        expired_q <= 1'b1;
                    end else if (bus.start_stop) begin
                        state     <= PAUSE;
                        running_q <= 1'b0;
                    end
                end
                PAUSE: begin
                    if (bus.start_stop) begin
                        state     <= RUN;
                        running_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.cont_dec  = dec_q;
    assign bus.cont_seg  = seg_q;
    assign bus.lap_dec   = lap_dec_q;
    assign bus.lap_seg   = lap_seg_q;
    assign bus.lap_valid = lap_valid_q;
    assign bus.running   = running_q;
    assign bus.expired   = expired_q;
    assign bus.tick      = tick_q;

endmodule

// File: doc/cronometro_ctrl.md
# cronometro_ctrl

Parametrised stopwatch/countdown-timer core with run/pause/clear control, lap capture and expiry detection. It is the next generation of the tenths/seconds counter. It sits between the debounced push-button front end and the 7-segment display driver, supplying the tenths and seconds values and status flags.

## Interface
- `CLK_PER_TENTH`, default 10: clk cycles per 0.1 s tick; legal values are 1 and above.
- `SEC_W`, default 10: width of the seconds counter.
- `SEC_MAX`, default 999: highest seconds value; must satisfy SEC_MAX < 2^SEC_W.
- `clk`, in, 1: single clock; all logic on posedge.
- `reset`, in, 1: asynchronous, active-low; clears all state.
- `start_stop`, in, 1: one-cycle pulse; toggles run/pause.
- `clear`, in, 1: one-cycle pulse; returns to IDLE.
- `lap`, in, 1: one-cycle pulse; captures the current value.
- `mode_down`, in, 1: 0 = count up, 1 = count down; sampled only on start from IDLE.
- `load_seg`, in, SEC_W: countdown start value in seconds; sampled with `mode_down`.
- `cont_dec`, out, 4: current tenths, range 0..9.
- `cont_seg`, out, SEC_W: current seconds, range 0..SEC_MAX.
- `lap_dec`, out, 4: captured tenths.
- `lap_seg`, out, SEC_W: captured seconds.
- `lap_valid`, out, 1: a lap value is held.
- `running`, out, 1: state is RUN.
- `expired`, out, 1: countdown reached 0.0.
- `tick`, out, 1: one-cycle pulse on each count step.

## Operation
- **States:** IDLE, RUN, PAUSE, DONE.
- **Reset values:** every output is 0; state is IDLE; prescaler is 0.
- **Input priority per cycle:** `clear` > `start_stop` > internal tick. `lap` is evaluated independently.
- **IDLE:**
  - Counters are 0.
  - `start_stop` moves to RUN and latches `mode_down`.
  - Down mode loads `cont_seg` = min(`load_seg`, SEC_MAX) and `cont_dec` = 0.
  - Down mode with `load_seg` == 0 goes straight to DONE with `expired` = 1.
- **RUN:**
  - Prescaler counts 0..CLK_PER_TENTH-1. On reaching the terminal value it returns to 0 and one step occurs.
  - **Up step:** `cont_dec` goes 9→0 carrying into `cont_seg`. From SEC_MAX.9 the count wraps to 0.0 and keeps running.
  - **Down step:** `cont_dec` goes 0→9 borrowing from `cont_seg`. The step that produces 0.0 enters DONE and sets `expired`.
  - `start_stop` moves to PAUSE.
- **PAUSE:**
  - Counters and prescaler phase hold.
  - `start_stop` returns to RUN; the prescaler resumes from its held value.
- **DONE:**
  - Counters hold 0.0 and `expired` = 1.
  - `start_stop` and `lap` are ignored; only `clear` exits.
- **clear:** from any state, go to IDLE. Counters, prescaler, lap registers, `lap_valid` and `expired` all go to 0.
- **lap:**
  - In RUN or PAUSE, copy the pre-edge `cont_dec`/`cont_seg` into the lap registers and set `lap_valid` = 1.
  - A later `lap` overwrites the held value; `lap_valid` stays 1 until `clear` or reset.
  - Ignored in IDLE and DONE.
- **start_stop and tick in the same RUN cycle:** the step is taken, then the state becomes PAUSE with the prescaler at 0.
- **Reset mid-count:** immediate return to the reset values, with no completion of the pending step.

## Timing
- All outputs are registered.
- The first step occurs CLK_PER_TENTH cycles after the edge that sampled `start_stop` in IDLE.
- Steps then recur every CLK_PER_TENTH cycles of RUN time; PAUSE time is excluded.
- `tick` is high for exactly the one cycle in which the new counter value first appears.
- With CLK_PER_TENTH = 1, a step occurs every RUN cycle.
- `lap_*` outputs are valid the cycle after the `lap` pulse.
- `expired` rises in the same cycle that 0.0 appears.
- `running` reflects the state one cycle after the controlling pulse.

## Structure
- **Package `cronometro_pkg`:**
  - state enum {IDLE, RUN, PAUSE, DONE};
  - constant DEC_MAX = 4'd9.
- **Sub-module `tick_gen`:** the prescaler.
  - Parameter CLK_PER_TENTH.
  - Ports: clk, reset, enable, clr, tick.
  - Counter width is $clog2(CLK_PER_TENTH+1).
- **Top level:** the FSM, BCD-style tenths/seconds step logic and lap registers.

## Test plan
All scenarios use CLK_PER_TENTH = 2, SEC_W = 4, SEC_MAX = 9.
- **Up count with wrap:** reset, pulse `start_stop` with `mode_down` = 0, run 200 cycles → `tick` every 2 cycles; `cont_seg.cont_dec` runs 0.1, 0.2, … 9.9, 0.0; `expired` stays 0.
- **Pause and resume:** start, wait 7 cycles, pulse `start_stop`, wait 20 cycles, pulse `start_stop` again → the value holds during PAUSE; the next tick follows the held prescaler phase; total steps equal RUN cycles / 2.
- **Countdown to expiry:** `load_seg` = 3, `mode_down` = 1, start → 3.0, 2.9, … 0.1, 0.0 after 60 cycles; DONE with `expired` = 1; a further `start_stop` has no effect; `clear` returns IDLE at 0.0.
- **Zero or oversize load:**
  - `load_seg` = 0 with down mode → DONE with `expired` = 1 on the next cycle.
  - `load_seg` = 15 → loads 9.0.
- **Lap capture:** `lap` at value 1.3 → `lap_seg` = 1, `lap_dec` = 3, `lap_valid` = 1, and counting continues. A second `lap` at 2.0 overwrites the captured value. `lap` in IDLE changes nothing.
- **Priority and reset:**
  - `clear` and `start_stop` in the same cycle → IDLE.
  - `start_stop` on a tick cycle → the step is taken, then PAUSE.
  - `reset` asserted mid-RUN → all outputs 0 before the next clk edge.
